// File: rtl/batch_sample_writer.sv
// Write-side front end of the batch sample store: packs OSR samples per RAM word,
// writes them into a 4-segment circular RAM and tracks segment credits/overrun.
module batch_sample_writer #(
   parameter int N = 4,
   parameter int OSR = 1,
   parameter int DEPTH = 220,
   localparam int DSD = (DEPTH + OSR - 1) / OSR,
   localparam int ADDR_W = $clog2(4 * DSD),
   localparam int SampleWidth = N * OSR
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   in_valid,
   input  logic [N-1:0]           in,
   input  logic                   seg_release,
   output logic                   sampleClk,
   output logic                   sampleWrite,
   output logic [ADDR_W-1:0]      sampleAddrIn,
   output logic [SampleWidth-1:0] sampleDataIn,
   output logic                   batch_done,
   output logic [1:0]             batch_idx,
   output logic [1:0]             credits,
   output logic                   overrun
);

   localparam int WORDS = 4 * DSD;
   localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;
   localparam int OFF_W = (DSD > 1) ? $clog2(DSD) : 1;

   logic [CNT_W-1:0]       pack_cnt;
   logic [SampleWidth-1:0] pack_buf;
   logic [SampleWidth-1:0] next_word;
   logic [ADDR_W-1:0]      wr_addr;
   logic [OFF_W-1:0]       wr_off;
   logic [1:0]             wr_seg;
   logic                   write_last;
   logic [1:0]             write_seg;
   logic                   cap;
   logic                   seg_end;
   logic                   enter;

   // The word being completed merges the buffered slots with the live sample.
   always_comb begin
      next_word = pack_buf;
      next_word[N * int'(pack_cnt) +: N] = in;
      cap     = in_valid && (pack_cnt == CNT_W'(OSR - 1));
      seg_end = (wr_off == OFF_W'(DSD - 1));
      enter   = cap && seg_end;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pack_cnt <= '0;
         pack_buf <= '0;
      end else if (in_valid) begin
         pack_buf <= next_word;
         pack_cnt <= cap ? '0 : pack_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sampleWrite  <= 1'b0;
         sampleClk    <= 1'b0;
         sampleDataIn <= '0;
         sampleAddrIn <= '0;
         write_last   <= 1'b0;
         write_seg    <= 2'd0;
         wr_addr      <= '0;
         wr_off       <= '0;
         wr_seg       <= 2'd0;
         batch_done   <= 1'b0;
         batch_idx    <= 2'd0;
      end else begin
         sampleWrite <= cap;
         sampleClk   <= sampleWrite;
         batch_done  <= sampleWrite && write_last;
         if (sampleWrite && write_last)
            batch_idx <= write_seg;
         if (cap) begin
            sampleDataIn <= next_word;
            sampleAddrIn <= wr_addr;
            write_last   <= seg_end;
            write_seg    <= wr_seg;
            wr_addr      <= (wr_addr == ADDR_W'(WORDS - 1)) ? '0 : wr_addr + ADDR_W'(1);
            wr_off       <= seg_end ? '0 : wr_off + OFF_W'(1);
            if (seg_end)
               wr_seg <= wr_seg + 2'd1;
         end
      end
   end

   // Segment entry consumes a credit; a coincident release cancels it out.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         credits <= 2'd3;
         overrun <= 1'b0;
      end else begin
         case ({enter, seg_release})
            2'b10: begin
               if (credits != 2'd0)
                  credits <= credits - 2'd1;
               else
                  overrun <= 1'b1;
            end
            2'b01: begin
               if (credits != 2'd3)
                  credits <= credits + 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_batch_sample_writer.sv
// Directed bench for batch_sample_writer with N=4, OSR=2, DEPTH=8 (16 words, 4 per segment).
module tb_batch_sample_writer;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       in_valid = 1'b0;
   logic [3:0] din = 4'h0;
   logic       seg_release = 1'b0;
   logic       sampleClk;
   logic       sampleWrite;
   logic [3:0] sampleAddrIn;
   logic [7:0] sampleDataIn;
   logic       batch_done;
   logic [1:0] batch_idx;
   logic [1:0] credits;
   logic       overrun;

   int passes = 0;
   int total  = 0;

   batch_sample_writer #(.N(4), .OSR(2), .DEPTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in(din), .seg_release(seg_release),
      .sampleClk(sampleClk), .sampleWrite(sampleWrite), .sampleAddrIn(sampleAddrIn),
      .sampleDataIn(sampleDataIn), .batch_done(batch_done), .batch_idx(batch_idx),
      .credits(credits), .overrun(overrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passes++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic tick(input logic v, input logic [3:0] d, input logic r);
      in_valid = v; din = d; seg_release = r;
      @(posedge clk); #1;
   endtask

   task automatic chk_idle_outs(input string tag);
      chk({tag, ".sw"}, 32'(sampleWrite), 0);
      chk({tag, ".sclk"}, 32'(sampleClk), 0);
      chk({tag, ".addr"}, 32'(sampleAddrIn), 0);
      chk({tag, ".data"}, 32'(sampleDataIn), 0);
      chk({tag, ".done"}, 32'(batch_done), 0);
      chk({tag, ".idx"}, 32'(batch_idx), 0);
      chk({tag, ".cred"}, 32'(credits), 3);
      chk({tag, ".ovr"}, 32'(overrun), 0);
   endtask

   task automatic do_reset();
      in_valid = 1'b0; seg_release = 1'b0; din = 4'h0;
      rst = 1'b0;
      @(posedge clk); #1;
      rst = 1'b1;
   endtask

   initial begin
      // reset values
      repeat (2) @(posedge clk);
      #1;
      chk_idle_outs("rst");
      rst = 1'b1;

      // packing: 1,2,3,4 -> 0x21 @0, 0x43 @1
      tick(1, 4'h1, 0); chk("pk0.sw", 32'(sampleWrite), 0);
      tick(1, 4'h2, 0); chk("pk1.sw", 32'(sampleWrite), 1);
      chk("pk1.data", 32'(sampleDataIn), 32'h21); chk("pk1.addr", 32'(sampleAddrIn), 0);
      chk("pk1.sclk", 32'(sampleClk), 0);
      tick(1, 4'h3, 0); chk("pk2.sw", 32'(sampleWrite), 0); chk("pk2.sclk", 32'(sampleClk), 1);
      chk("pk2.data", 32'(sampleDataIn), 32'h21); chk("pk2.addr", 32'(sampleAddrIn), 0);
      tick(1, 4'h4, 0); chk("pk3.sw", 32'(sampleWrite), 1);
      chk("pk3.data", 32'(sampleDataIn), 32'h43); chk("pk3.addr", 32'(sampleAddrIn), 1);
      chk("pk3.sclk", 32'(sampleClk), 0);
      tick(0, 4'h0, 0); chk("pk4.sclk", 32'(sampleClk), 1); chk("pk4.sw", 32'(sampleWrite), 0);

      // gaps: 5, idle x3, 6 -> single write 0x65 @2
      tick(1, 4'h5, 0); chk("gap0.sw", 32'(sampleWrite), 0);
      for (int k = 0; k < 3; k++) begin
         tick(0, 4'hf, 0);
         chk("gap_idle.sw", 32'(sampleWrite), 0);
         chk("gap_idle.sclk", 32'(sampleClk), 0);
      end
      tick(1, 4'h6, 0); chk("gap1.sw", 32'(sampleWrite), 1);
      chk("gap1.data", 32'(sampleDataIn), 32'h65); chk("gap1.addr", 32'(sampleAddrIn), 2);
      tick(0, 4'h0, 0); chk("gap2.sclk", 32'(sampleClk), 1);

      // async reset mid-word: outputs clear without a clock edge
      tick(1, 4'h7, 0);
      in_valid = 1'b0;
      rst = 1'b0; #1;
      chk_idle_outs("arst");
      @(posedge clk); #1;
      rst = 1'b1;
      tick(1, 4'h1, 0);
      tick(1, 4'h2, 0);
      chk("arst_pk.data", 32'(sampleDataIn), 32'h21); chk("arst_pk.addr", 32'(sampleAddrIn), 0);
      chk("arst_pk.sw", 32'(sampleWrite), 1);

      // segments, wrap, credits and overrun over 32 samples
      do_reset();
      for (int i = 0; i <= 32; i++) begin
         int entries;
         int w;
         if (i < 32) tick(1, 4'(i), 0);
         else tick(0, 4'h0, 0);
         entries = (i >= 7) + (i >= 15) + (i >= 23) + (i >= 31);
         chk("seg.sw", 32'(sampleWrite), (i % 2 == 1 && i < 32) ? 1 : 0);
         chk("seg.sclk", 32'(sampleClk), (i % 2 == 0 && i >= 2) ? 1 : 0);
         if (i % 2 == 1 && i < 32) begin
            w = i / 2;
            chk("seg.addr", 32'(sampleAddrIn), 32'(w % 16));
            chk("seg.data", 32'(sampleDataIn), 32'({4'(i), 4'(i - 1)}));
         end
         if (i % 2 == 0 && i >= 2 && ((i - 2) / 2) % 4 == 3) begin
            chk("seg.done", 32'(batch_done), 1);
            chk("seg.idx", 32'(batch_idx), 32'(((i - 2) / 2) / 4));
         end else begin
            chk("seg.done", 32'(batch_done), 0);
         end
         chk("seg.cred", 32'(credits), 32'((entries > 3) ? 0 : 3 - entries));
         chk("seg.ovr", 32'(overrun), (entries >= 4) ? 1 : 0);
      end
      tick(1, 4'ha, 0);
      tick(1, 4'hb, 0);
      chk("wrap.sw", 32'(sampleWrite), 1);
      chk("wrap.addr", 32'(sampleAddrIn), 0);
      chk("wrap.data", 32'(sampleDataIn), 32'hba);
      chk("wrap.ovr", 32'(overrun), 1);
      chk("wrap.cred", 32'(credits), 0);

      // release coinciding with segment entry at credits=0
      do_reset();
      for (int i = 0; i < 24; i++) tick(1, 4'(i), 0);
      chk("rel.cred0", 32'(credits), 0);
      chk("rel.ovr0", 32'(overrun), 0);
      for (int i = 24; i < 31; i++) tick(1, 4'(i), 0);
      tick(1, 4'hf, 1);
      chk("rel.coinc.cred", 32'(credits), 0);
      chk("rel.coinc.ovr", 32'(overrun), 0);
      chk("rel.coinc.addr", 32'(sampleAddrIn), 15);
      tick(0, 4'h0, 0);
      chk("rel.coinc.done", 32'(batch_done), 1);
      chk("rel.coinc.idx", 32'(batch_idx), 3);
      tick(0, 4'h0, 1); chk("rel.r1", 32'(credits), 1);
      tick(0, 4'h0, 1); chk("rel.r2", 32'(credits), 2);
      for (int k = 0; k < 4; k++) begin
         tick(0, 4'h0, 1);
         chk("rel.sat", 32'(credits), 3);
      end
      tick(0, 4'h0, 0);
      chk("rel.ovr_end", 32'(overrun), 0);

      $display("%0d/%0d checks passed", passes, total);
      $finish;
   end

endmodule
